// File: rtl/sm4_pkg.sv
// Shared SM4 definitions: FK whitening words, S-box, schedule state enum
// and the word/index typedefs used across the key-schedule slice.
package sm4_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  rnd_idx_t;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    READY
  } sched_state_t;

  localparam word_t FK0 = 32'ha3b1bac6;
  localparam word_t FK1 = 32'h56aa3350;
  localparam word_t FK2 = 32'h677d9197;
  localparam word_t FK3 = 32'hb27022dc;

  localparam logic [7:0] SBOX [256] = '{
    8'hd6, 8'h90, 8'he9, 8'hfe, 8'hcc, 8'he1, 8'h3d, 8'hb7, 8'h16, 8'hb6, 8'h14, 8'hc2, 8'h28, 8'hfb, 8'h2c, 8'h05,
    8'h2b, 8'h67, 8'h9a, 8'h76, 8'h2a, 8'hbe, 8'h04, 8'hc3, 8'haa, 8'h44, 8'h13, 8'h26, 8'h49, 8'h86, 8'h06, 8'h99,
    8'h9c, 8'h42, 8'h50, 8'hf4, 8'h91, 8'hef, 8'h98, 8'h7a, 8'h33, 8'h54, 8'h0b, 8'h43, 8'hed, 8'hcf, 8'hac, 8'h62,
    8'he4, 8'hb3, 8'h1c, 8'ha9, 8'hc9, 8'h08, 8'he8, 8'h95, 8'h80, 8'hdf, 8'h94, 8'hfa, 8'h75, 8'h8f, 8'h3f, 8'ha6,
    8'h47, 8'h07, 8'ha7, 8'hfc, 8'hf3, 8'h73, 8'h17, 8'hba, 8'h83, 8'h59, 8'h3c, 8'h19, 8'he6, 8'h85, 8'h4f, 8'ha8,
    8'h68, 8'h6b, 8'h81, 8'hb2, 8'h71, 8'h64, 8'hda, 8'h8b, 8'hf8, 8'heb, 8'h0f, 8'h4b, 8'h70, 8'h56, 8'h9d, 8'h35,
    8'h1e, 8'h24, 8'h0e, 8'h5e, 8'h63, 8'h58, 8'hd1, 8'ha2, 8'h25, 8'h22, 8'h7c, 8'h3b, 8'h01, 8'h21, 8'h78, 8'h87,
    8'hd4, 8'h00, 8'h46, 8'h57, 8'h9f, 8'hd3, 8'h27, 8'h52, 8'h4c, 8'h36, 8'h02, 8'he7, 8'ha0, 8'hc4, 8'hc8, 8'h9e,
    8'hea, 8'hbf, 8'h8a, 8'hd2, 8'h40, 8'hc7, 8'h38, 8'hb5, 8'ha3, 8'hf7, 8'hf2, 8'hce, 8'hf9, 8'h61, 8'h15, 8'ha1,
    8'he0, 8'hae, 8'h5d, 8'ha4, 8'h9b, 8'h34, 8'h1a, 8'h55, 8'had, 8'h93, 8'h32, 8'h30, 8'hf5, 8'h8c, 8'hb1, 8'he3,
    8'h1d, 8'hf6, 8'he2, 8'h2e, 8'h82, 8'h66, 8'hca, 8'h60, 8'hc0, 8'h29, 8'h23, 8'hab, 8'h0d, 8'h53, 8'h4e, 8'h6f,
    8'hd5, 8'hdb, 8'h37, 8'h45, 8'hde, 8'hfd, 8'h8e, 8'h2f, 8'h03, 8'hff, 8'h6a, 8'h72, 8'h6d, 8'h6c, 8'h5b, 8'h51,
    8'h8d, 8'h1b, 8'haf, 8'h92, 8'hbb, 8'hdd, 8'hbc, 8'h7f, 8'h11, 8'hd9, 8'h5c, 8'h41, 8'h1f, 8'h10, 8'h5a, 8'hd8,
    8'h0a, 8'hc1, 8'h31, 8'h88, 8'ha5, 8'hcd, 8'h7b, 8'hbd, 8'h2d, 8'h74, 8'hd0, 8'h12, 8'hb8, 8'he5, 8'hb4, 8'hb0,
    8'h89, 8'h69, 8'h97, 8'h4a, 8'h0c, 8'h96, 8'h77, 8'h7e, 8'h65, 8'hb9, 8'hf1, 8'h09, 8'hc5, 8'h6e, 8'hc6, 8'h84,
    8'h18, 8'hf0, 8'h7d, 8'hec, 8'h3a, 8'hdc, 8'h4d, 8'h20, 8'h79, 8'hee, 8'h5f, 8'h3e, 8'hd7, 8'hcb, 8'h39, 8'h48
  };

endpackage

// File: rtl/sm4_key_tau_lp.sv
// Combinational key-schedule transform T': four parallel S-box lookups (tau)
// followed by the key-side linear mix L'(B) = B ^ (B<<<13) ^ (B<<<23).
module sm4_key_tau_lp
  import sm4_pkg::*;
(
  input  logic [31:0] a,
  output logic [31:0] y
);

  word_t b;

  // Byte-wise substitution then the two-rotate linear layer.
  always_comb begin
    b = {SBOX[a[31:24]], SBOX[a[23:16]], SBOX[a[15:8]], SBOX[a[7:0]]};
    y = b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
  end

endmodule

// File: rtl/sm4_key_sched.sv
// Iterative SM4 key schedule: FK-whitened key window, one expansion round per
// cycle into a 32-entry round-key store, then indexed reads (ascending for
// encryption, reversed for decryption).
// Optional feature macro: SM4_RK_STREAM_EN adds a registered stream of each
// round key as it is produced.
module sm4_key_sched
  import sm4_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         key_valid_in,
  output logic         key_ready_out,
  input  logic [127:0] key_in,
  input  logic         rk_req_in,
  input  logic [4:0]   rk_index_in,
  input  logic         rk_dec_in,
  output logic         rk_valid_out,
  output logic [31:0]  rk_out,
  output logic         busy_out,
`ifdef SM4_RK_STREAM_EN
  output logic         rk_stream_valid_out,
  output logic [31:0]  rk_stream_out,
`endif
  output logic         sched_done_out
);

  sched_state_t state, state_nxt;
  rnd_idx_t     cnt;
  rnd_idx_t     rd_addr;
  word_t        k0, k1, k2, k3;
  word_t        rk_store [32];
  word_t        ck, tau_out, rk_new;
  logic         key_hs;

  assign key_ready_out  = (state == IDLE) || (state == READY);
  assign key_hs         = key_valid_in && key_ready_out;
  assign busy_out       = (state == EXPAND);
  assign sched_done_out = (state == READY);
  assign rd_addr        = rk_dec_in ? (5'd31 - rk_index_in) : rk_index_in;

  // Round constant CK[cnt]: byte j (MSB first) is ((4*cnt + j) * 7) mod 256.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
    ck = '0;
    for (int j = 0; j < 4; j++) begin
      ck[8*(3-j) +: 8] = 8'(({1'b0, cnt, 2'b00} + 8'(j)) * 8'd7);
    end
  end

  sm4_key_tau_lp u_tau_lp (
    .a (k1 ^ k2 ^ k3 ^ ck),
    .y (tau_out)
  );

  assign rk_new = k0 ^ tau_out;

  // Next-state logic: load, 32 expansion rounds, then serve reads until re-key.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (key_hs) state_nxt = EXPAND;
      EXPAND:  if (cnt == 5'd31) state_nxt = READY;
      READY:   if (key_hs) state_nxt = EXPAND;
      default: state_nxt = IDLE;
    endcase
  end

  // Control state, round counter and registered read / stream outputs.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      rk_valid_out <= 1'b0;
      rk_out       <= '0;
`ifdef SM4_RK_STREAM_EN
      rk_stream_valid_out <= 1'b0;
      rk_stream_out       <= '0;
`endif
    end else begin
      state <= state_nxt;
      if (key_hs) begin
        cnt <= '0;
      end else if (state == EXPAND) begin
        cnt <= cnt + 5'd1;
      end
      // A key load in READY takes priority over a read in the same cycle.
      rk_valid_out <= (state == READY) && rk_req_in && !key_hs;
      if ((state == READY) && rk_req_in && !key_hs) begin
        rk_out <= rk_store[rd_addr];
      end
`ifdef SM4_RK_STREAM_EN
      rk_stream_valid_out <= (state == EXPAND);
      if (state == EXPAND) begin
        rk_stream_out <= rk_new;
      end
`endif
    end
  end

  // Key window and round-key store: whitened load on handshake, shift per round.
  always_ff @(posedge clk) begin
    // NOTE: store and window are deliberately unreset; they are always rewritten before being read as valid.
    if (key_hs) begin
      k0 <= key_in[127:96] ^ FK0;
      k1 <= key_in[95:64]  ^ FK1;
      k2 <= key_in[63:32]  ^ FK2;
      k3 <= key_in[31:0]   ^ FK3;
    end else if (state == EXPAND) begin
      rk_store[cnt] <= rk_new;
      k0 <= k1;
      k1 <= k2;
      k2 <= k3;
      k3 <= rk_new;
    end
  end

endmodule
